// File: rtl/reg_sched_pkg.sv
// -----------------------------------------------------------------------------
// reg_sched_pkg
// Shared constants and types for the register-file write scheduler.
//   NREQ_DEF/AW_DEF/DW_DEF : default requester count, address and data widths
//   REQ_*                  : requester indices, index 0 is oldest in program order
//   RA_REG / CPU_REG       : fixed destination registers of the E-stage link
//                            and branch-unit PC writers
//   slot_t                 : one holding-slot record
// -----------------------------------------------------------------------------
package reg_sched_pkg;

    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned AW_DEF   = 5;
    localparam int unsigned DW_DEF   = 32;

    localparam int unsigned REQ_W = 0;
    localparam int unsigned REQ_M = 1;
    localparam int unsigned REQ_E = 2;
    localparam int unsigned REQ_C = 3;

    localparam logic [AW_DEF-1:0] RA_REG  = 5'd31;
    localparam logic [AW_DEF-1:0] CPU_REG = 5'd30;

    typedef struct packed {
        logic              valid;
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] data;
    } slot_t;

endpackage

// File: rtl/age_matrix_arbiter.sv
// -----------------------------------------------------------------------------
// age_matrix_arbiter
// Tracks relative age of NREQ slots in an NREQ x NREQ matrix and grants the
// oldest valid slot. older_q[j][i]=1 means slot j is older than slot i.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears the matrix)
//   valid_i    : slots currently holding a write
//   load_i     : slots being (re)filled at the coming edge
//   keep_i     : slots that stay valid across the edge without being reloaded
//   grant_o    : one-hot grant to the oldest valid slot (zero if none valid)
// -----------------------------------------------------------------------------
module age_matrix_arbiter
    import reg_sched_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] valid_i,
    input  logic [NREQ-1:0] load_i,
    input  logic [NREQ-1:0] keep_i,
    output logic [NREQ-1:0] grant_o
);

    logic [NREQ-1:0] older_q [NREQ];
    logic [NREQ-1:0] older_d [NREQ];
    logic            blocked;

    // A slot wins when no other valid slot is marked older than it. Entries
    // for invalid slots may be stale; they are masked by valid_i here and
    // rewritten whenever that slot loads again.
    always_comb begin
        grant_o = '0;
        blocked = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            blocked = 1'b0;
            for (int unsigned j = 0; j < NREQ; j++) begin
                if (j != i && valid_i[j] && older_q[j][i]) begin
                    blocked = 1'b1;
                end
            end
            grant_o[i] = valid_i[i] & ~blocked;
        end
    end

    // Loading column j: every surviving slot becomes older than j, and of the
    // slots loading together the lower index is older. A loaded row is cleared
    // against everything not loading this cycle (it is the youngest).
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            older_d[i] = older_q[i];
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            for (int unsigned j = 0; j < NREQ; j++) begin
                if (i != j) begin
                    if (load_i[j]) begin
                        older_d[i][j] = keep_i[i] || (load_i[i] && (i < j));
                    end else if (load_i[i]) begin
                        older_d[i][j] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                older_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                older_q[i] <= older_d[i];
            end
        end
    end

endmodule

// File: rtl/reg_write_scheduler.sv
// -----------------------------------------------------------------------------
// reg_write_scheduler
// Shares the register-file write port between NREQ pipeline writers. Each
// writer owns a one-entry slot; the oldest slot drains onto a registered
// write port, one write per cycle. Superseded writes to the same register are
// dropped and a pending mask marks registers with a write in flight.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   req_valid    : per-requester write request
//   req_addr     : packed target registers, requester i at [i*AW +: AW]
//   req_data     : packed write data, requester i at [i*DW +: DW]
//   req_ready    : slot free or draining this cycle
//   wr_en        : registered write strobe
//   wr_addr      : registered write address (holds when idle)
//   wr_data      : registered write data (holds when idle)
//   pending_mask : bit r set while a write to r is queued or on the port
//   idle         : no queued write and no write on the port
// -----------------------------------------------------------------------------
module reg_write_scheduler
    import reg_sched_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned AW   = AW_DEF,
    parameter int unsigned DW   = DW_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               wr_en,
    output logic [AW-1:0]      wr_addr,
    output logic [DW-1:0]      wr_data,
    output logic [31:0]        pending_mask,
    output logic               idle
);

    logic [NREQ-1:0] slot_valid_q, slot_valid_d;
    logic [AW-1:0]   slot_addr_q [NREQ];
    logic [AW-1:0]   slot_addr_d [NREQ];
    logic [DW-1:0]   slot_data_q [NREQ];
    logic [DW-1:0]   slot_data_d [NREQ];

    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;

    logic [AW-1:0]   in_addr [NREQ];
    logic [DW-1:0]   in_data [NREQ];
    logic [NREQ-1:0] grant, acc_nz, load, kill, keep;
    logic [31:0]     pend;

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            in_addr[i] = req_addr[i*AW +: AW];
            in_data[i] = req_data[i*DW +: DW];
        end
    end

    age_matrix_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (slot_valid_q),
        .load_i  (load),
        .keep_i  (keep),
        .grant_o (grant)
    );

    assign req_ready = ~slot_valid_q | grant;

    // r0 requests are accepted but never fill a slot. Of several requests to
    // the same register accepted together, only the highest index (youngest)
    // loads.
    always_comb begin
        acc_nz = '0;
        load   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            acc_nz[i] = req_valid[i] & req_ready[i] & (in_addr[i] != '0);
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            load[i] = acc_nz[i];
            for (int unsigned j = i + 1; j < NREQ; j++) begin
                if (acc_nz[j] && in_addr[j] == in_addr[i]) begin
                    load[i] = 1'b0;
                end
            end
        end
    end

    // A newly loaded write kills an older queued write to the same register,
    // unless that one is granted now; it then issues first and the newer
    // value lands afterwards.
    always_comb begin
        kill = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (i != k && load[i] && in_addr[i] == slot_addr_q[k]) begin
                    kill[k] = 1'b1;
                end
            end
            kill[k] = kill[k] & slot_valid_q[k] & ~grant[k];
        end
    end

    always_comb begin
        slot_valid_d = (slot_valid_q & ~grant & ~kill) | load;
        keep         = slot_valid_d & ~load;
        for (int unsigned i = 0; i < NREQ; i++) begin
            slot_addr_d[i] = load[i] ? in_addr[i] : slot_addr_q[i];
            slot_data_d[i] = load[i] ? in_data[i] : slot_data_q[i];
        end
    end

    always_comb begin
        wr_en_d   = |grant;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                wr_addr_d = slot_addr_q[i];
                wr_data_d = slot_data_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid_q <= '0;
            for (int unsigned i = 0; i < NREQ; i++) begin
                slot_addr_q[i] <= '0;
                slot_data_q[i] <= '0;
            end
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            for (int unsigned i = 0; i < NREQ; i++) begin
                slot_addr_q[i] <= slot_addr_d[i];
                slot_data_q[i] <= slot_data_d[i];
            end
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        pend = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (slot_valid_q[i]) begin
                pend = pend | (32'd1 << slot_addr_q[i]);
            end
        end
        if (wr_en_q) begin
            pend = pend | (32'd1 << wr_addr_q);
        end
        pend[0] = 1'b0;
    end

    assign pending_mask = pend;
    assign idle         = ~|slot_valid_q & ~wr_en_q;
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;

endmodule

// File: doc/reg_write_scheduler.md
Name: reg_write_scheduler

Overview:
- Shares the register file's write path between four pipeline writers: W-stage result, M-stage bypass result, E-stage link ($ra) and the branch unit's stored PC.
- Each writer gets a one-entry holding slot. An age-ordered arbiter drains the slots onto a single registered write port.
- Superseded writes to the same register are dropped.
- Exports a pending-register mask so hazard logic can stall readers of registers that have a write in flight.

Parameters:
- NREQ, 4, number of requesters. Index 0 is the oldest in program order.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester write request.
- req_addr  input  NREQ*AW  packed target register numbers; requester i uses bits [i*AW +: AW].
- req_data  input  NREQ*DW  packed write data; requester i uses bits [i*DW +: DW].
- req_ready  output  NREQ  slot free (or draining this cycle); a request is accepted when req_valid and req_ready are both high.
- wr_en  output  1  registered write strobe to the register file.
- wr_addr  output  AW  registered write address.
- wr_data  output  DW  registered write data.
- pending_mask  output  32  bit r set while a write to register r is queued or on the write port.
- idle  output  1  no valid slot and wr_en low.

Behaviour:
- Reset (asynchronous, on rst_n low):
  - All slots invalid; age matrix cleared.
  - wr_en=0, wr_addr=0, wr_data=0, pending_mask=0, idle=1.
  - req_ready is all ones whenever slots are empty.
- Reset mid-operation: queued writes are discarded and no write issues after release. wr_en falls asynchronously.
- req_ready[i] = !slot_valid[i] OR grant[i] in the current cycle; this is combinational from state.
- Acceptance loads slot i with addr/data at the clock edge.
- Writes to r0 are accepted and discarded: the slot is not filled and the pending bit is not set.
- Age tracking uses an NREQ x NREQ matrix, older[j][i]=1 meaning slot j is older than slot i.
  - On load of slot i: older[j][i]=1 for every other slot j that remains valid; older[i][j]=0.
  - Same-cycle loads: the lower index is older.
  - No counters are used, so there is no wrap-around.
- Grant: at most one per cycle, to the valid slot with no older valid slot.
  - The granted slot clears at the edge.
  - wr_en/wr_addr/wr_data are loaded from it at the same edge and are therefore visible in the following cycle.
  - With no grant, wr_en=0 and addr/data hold their last value.
- Latency:
  - Request accepted in cycle N; slot valid and granted in cycle N+1 if it is oldest; wr_en high in cycle N+2.
  - Sustained throughput is one write per cycle.
- Supersede rule, when a request to register A is accepted:
  - Any other valid, non-granted slot holding A is invalidated at the same edge.
  - Any simultaneously accepted older request to A is dropped.
  - A slot holding A that is granted in that cycle still issues; the newer write issues later, so the final value is the younger one.
- pending_mask[r] = OR over valid slots with addr r, OR (wr_en AND wr_addr==r). It is computed from registered state; bit 0 is always 0.
- idle = no valid slot AND !wr_en.
- Backpressure: a requester whose slot is full and not granted sees req_ready=0 and must hold valid/addr/data stable.

Decomposition:
- Package reg_sched_pkg:
  - NREQ/AW/DW defaults.
  - Requester indices REQ_W=0, REQ_M=1, REQ_E=2, REQ_C=3.
  - Fixed register numbers RA_REG=31, CPU_REG=30.
  - Slot record typedef (valid, addr, data).
- Sub-module age_matrix_arbiter: holds the matrix, takes load/valid vectors, returns a one-hot grant. Everything else stays in the top level.

Test Plan:
- Single write: M requests r5=0x00001234 in cycle 1 → wr_en=1 with wr_addr=5 and wr_data=0x00001234 in cycle 3 only; pending_mask[5]=1 in cycles 2–3 and 0 in cycle 4; idle returns to 1 in cycle 4.
- All four requesters in the same cycle (W r1=0x11, M r2=0x22, E r31=0x31, C r30=0x30) → four consecutive wr_en cycles with addresses 1, 2, 31, 30; req_ready of each requester rises again in its grant cycle.
- Same-cycle conflict: W r7=0xA and M r7=0xB → exactly one write, r7=0xB; pending_mask[7] clears after it.
- r0 write: W requests r0=0xFFFFFFFF → accepted (ready=1), no wr_en, pending_mask stays 0, idle stays 1.
- Age over index: hold wr_en busy with E, C and M slots queued, then W arrives later → W issues after E, C and M, not before; a full W slot with req_valid held keeps req_ready=0 until its grant.
- Reset: three slots pending, drop rst_n mid-cycle → wr_en=0 immediately; after release, no wr_en for 5 cycles, idle=1 and pending_mask=0.
